handshake_protocol_monitor: RTL and testbench
=============================================

Name: handshake_protocol_monitor

Overview:
- Parametrised, passive ready/valid protocol checker for N_CH independent channels; bound alongside a DUT, never drives DUT signals.
- Replaces single-cycle, single-property monitors with per-channel sequential checks:
  - valid must hold until accepted
  - data must be stable while stalled
  - bounded stall length
  - transfer counting
- Sticky error flags plus first-error capture feed the testbench scoreboard and formal cover/assert wrappers.

Parameters:
- N_CH, 3: number of monitored channels.
- DATA_W, 4: payload width per channel.
- MAX_STALL, 15: stall cycles (valid=1, ready=0) tolerated before a timeout error; legal range 1..2^16-1.
- CNT_W, 16: width of each per-channel transfer counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of error flags and first-error capture; counters unaffected.
- valid  in  N_CH  per-channel valid; bit i is channel i.
- ready  in  N_CH  per-channel ready.
- data  in  N_CH*DATA_W  payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- err_valid_drop  out  N_CH  sticky: valid deasserted before acceptance.
- err_data_change  out  N_CH  sticky: data changed while stalled.
- err_stall_timeout  out  N_CH  sticky: stall reached MAX_STALL cycles.
- xfer_count  out  N_CH*CNT_W  per-channel accepted-transfer count, saturating.
- any_error  out  1  OR of all error flags (registered).
- first_err_valid  out  1  a first error has been captured.
- first_err_ch  out  clog2(N_CH) (min 1)  channel index of first error.

Behaviour:
- Reset (RESET=1 at edge): all outputs 0, all channel FSMs IDLE, stall counters 0, shadow data 0. Reset mid-stall discards the pending transaction; no error is raised for it.
- Transfer: valid[i]&ready[i] at an edge. xfer_count[i] += 1 on the next edge; holds at 2^CNT_W-1.
- Per-channel FSM, states IDLE and WAIT:
  - IDLE, valid&!ready: go to WAIT; shadow <= data[i]; stall_cnt <= 1.
  - IDLE, valid&ready: transfer; stay IDLE.
  - IDLE, !valid: stay IDLE.
  - WAIT, !valid: set err_valid_drop[i]; go to IDLE; stall_cnt <= 0.
  - WAIT, valid&ready: transfer; go to IDLE; stall_cnt <= 0. Data is still compared to shadow on this edge; a mismatch sets err_data_change[i] and the transfer is still counted.
  - WAIT, valid&!ready: stay WAIT; stall_cnt += 1, saturating at MAX_STALL. A data mismatch sets err_data_change[i]; shadow is not updated.
- Timeout: err_stall_timeout[i] sets on the edge where stall_cnt becomes MAX_STALL (checked in both the IDLE->WAIT and WAIT->WAIT transitions, so MAX_STALL=1 fires on the first stall cycle). Fires at most once per stall episode.
- Latency: all error flags, any_error and counts are registered, visible one cycle after the violating edge.
- Sticky flags: remain set until clear or RESET.
- Simultaneous clear and new violation on the same edge: the violation wins and the flag is set.
- clear does not alter FSM state, stall_cnt or shadow.
- First error:
  - On the edge where any flag goes 0->1 while first_err_valid=0, latch first_err_valid=1 and first_err_ch = lowest-index channel with a new error on that edge.
  - Later errors do not overwrite the capture until clear/RESET.
- Channels are fully independent; no cross-channel ordering is checked.

Test Plan (N_CH=3, DATA_W=4, MAX_STALL=4, CNT_W=16):
- Clean traffic: ch0 valid=ready=1 for 5 cycles, ch1 two stalled transfers holding data stable -> xfer_count ch0=5, ch1=2, all error flags 0, first_err_valid=0.
- Valid drop: ch1 valid=1, ready=0, data=4'hA for 2 cycles, then valid=0 -> err_valid_drop=3'b010 one cycle later, any_error=1, first_err_ch=1, xfer_count ch1 unchanged.
- Data change: ch2 stalled with data 4'h3, changes to 4'h5 while ready=0, accepted next cycle -> err_data_change=3'b100, xfer_count ch2=1.
- Timeout: ch0 valid=1, ready=0 for 6 cycles -> err_stall_timeout[0] rises after the 4th stall edge, asserted once, no toggle thereafter.
- Simultaneous errors and clear: ch0 and ch2 violate on the same edge -> first_err_ch=0. Then clear=1 on an edge with a new ch1 drop -> only err_valid_drop[1] set, first_err_ch=1.
- Reset mid-stall and saturation: RESET during a ch1 stall -> all outputs 0 next cycle, no error after release. Preload-free run of 2^16+2 ch0 transfers (CNT_W=16) -> xfer_count ch0=16'hFFFF.

Source files
------------

// File: rtl/handshake_protocol_monitor_if.sv
// Ready/valid bundle for N_CH independent channels.
// Ports: valid, ready (N_CH), data (N_CH*DATA_W); master/slave/monitor views.
interface handshake_protocol_monitor_if #(
   parameter int N_CH   = 3,
   parameter int DATA_W = 4
);
   logic [N_CH-1:0]        valid;
   logic [N_CH-1:0]        ready;
   logic [N_CH*DATA_W-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

   // Passive observer: sees everything, drives nothing.
   modport monitor (
      input valid,
      input ready,
      input data
   );
endinterface

// File: rtl/handshake_protocol_monitor.sv
// Passive per-channel ready/valid protocol checker with sticky errors.
// Ports: CLK, RESET, clear, bus (monitor), err_* flags, xfer_count, first_err_*.
module handshake_protocol_monitor #(
   parameter int N_CH      = 3,
   parameter int DATA_W    = 4,
   parameter int MAX_STALL = 15,
   parameter int CNT_W     = 16
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    clear,
   handshake_protocol_monitor_if.monitor bus,
   output logic [N_CH-1:0]         err_valid_drop,
   output logic [N_CH-1:0]         err_data_change,
   output logic [N_CH-1:0]         err_stall_timeout,
   output logic [N_CH*CNT_W-1:0]   xfer_count,
   output logic                    any_error,
   output logic                    first_err_valid,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_err_ch
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SW   = $clog2(MAX_STALL + 1);
   localparam logic [SW-1:0] MS = SW'(MAX_STALL);

   typedef enum logic {IDLE, WAIT} st_t;

   st_t               st_q     [N_CH];
   st_t               st_d     [N_CH];
   logic [SW-1:0]     stall_q  [N_CH];
   logic [SW-1:0]     stall_d  [N_CH];
   logic [DATA_W-1:0] shadow_q [N_CH];
   logic [DATA_W-1:0] shadow_d [N_CH];
   logic [CNT_W-1:0]  cnt_q    [N_CH];

   logic [N_CH-1:0] new_vd, new_dc, new_to, xfer;
   logic [N_CH-1:0] vd_keep, dc_keep, to_keep;
   logic [N_CH-1:0] vd_d, dc_d, to_d, rise;
   logic            fev_d;
   logic [CH_W-1:0] fch_d;

   // Channel FSMs: next state, stall count, shadow and violations.
   always_comb begin
      new_vd = '0;
      new_dc = '0;
      new_to = '0;
      xfer   = '0;
      for (int i = 0; i < N_CH; i++) begin
         logic [DATA_W-1:0] d;
         d           = bus.data[i*DATA_W +: DATA_W];
         st_d[i]     = st_q[i];
         stall_d[i]  = stall_q[i];
         shadow_d[i] = shadow_q[i];
         xfer[i]     = bus.valid[i] & bus.ready[i];
         unique case (st_q[i])
            IDLE: begin
               if (bus.valid[i] && !bus.ready[i]) begin
                  st_d[i]     = WAIT;
                  shadow_d[i] = d;
                  stall_d[i]  = SW'(1);
                  if (MS == SW'(1)) new_to[i] = 1'b1;
               end
            end
            WAIT: begin
               if (!bus.valid[i]) begin
                  new_vd[i]  = 1'b1;
                  st_d[i]    = IDLE;
                  stall_d[i] = '0;
               end else begin
                  if (d != shadow_q[i]) new_dc[i] = 1'b1;
                  if (bus.ready[i]) begin
                     st_d[i]    = IDLE;
                     stall_d[i] = '0;
                  end else if (stall_q[i] < MS) begin
                     // Saturation keeps timeout to one shot per episode.
                     stall_d[i] = stall_q[i] + SW'(1);
                     if (stall_d[i] == MS) new_to[i] = 1'b1;
                  end
               end
            end
            default: st_d[i] = IDLE;
         endcase
      end
   end

   // Sticky flags; a violation on a clear edge still sets its flag.
   always_comb begin
      vd_keep = clear ? '0 : err_valid_drop;
      dc_keep = clear ? '0 : err_data_change;
      to_keep = clear ? '0 : err_stall_timeout;
      vd_d    = vd_keep | new_vd;
      dc_d    = dc_keep | new_dc;
      to_d    = to_keep | new_to;
      rise    = (new_vd & ~vd_keep) | (new_dc & ~dc_keep)
              | (new_to & ~to_keep);
      fev_d   = clear ? 1'b0 : first_err_valid;
      fch_d   = clear ? '0 : first_err_ch;
      if (!fev_d && (|rise)) begin
         fev_d = 1'b1;
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (rise[i]) fch_d = CH_W'(i);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         err_valid_drop    <= '0;
         err_data_change   <= '0;
         err_stall_timeout <= '0;
         any_error         <= 1'b0;
         first_err_valid   <= 1'b0;
         first_err_ch      <= '0;
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]     <= IDLE;
            stall_q[i]  <= '0;
            shadow_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         err_valid_drop    <= vd_d;
         err_data_change   <= dc_d;
         err_stall_timeout <= to_d;
         any_error         <= |{vd_d, dc_d, to_d};
         first_err_valid   <= fev_d;
         first_err_ch      <= fch_d;
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]     <= st_d[i];
            stall_q[i]  <= stall_d[i];
            shadow_q[i] <= shadow_d[i];
            if (xfer[i] && (cnt_q[i] != '1))
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt
      assign xfer_count[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Directed bench for handshake_protocol_monitor (N_CH=3, MAX_STALL=4).
// Drives the bus interface, checks flags, counts and first-error capture.
module tb_handshake_protocol_monitor;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        clear;
   logic [2:0]  err_valid_drop, err_data_change, err_stall_timeout;
   logic [47:0] xfer_count;
   logic        any_error, first_err_valid;
   logic [1:0]  first_err_ch;
   int          total = 0;
   int          bad = 0;

   handshake_protocol_monitor_if #(.N_CH(3), .DATA_W(4)) bus ();

   handshake_protocol_monitor #(
      .N_CH(3), .DATA_W(4), .MAX_STALL(4), .CNT_W(16)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .clear(clear),
      .bus(bus),
      .err_valid_drop(err_valid_drop),
      .err_data_change(err_data_change),
      .err_stall_timeout(err_stall_timeout),
      .xfer_count(xfer_count),
      .any_error(any_error),
      .first_err_valid(first_err_valid),
      .first_err_ch(first_err_ch)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] cnt(input int ch);
      return xfer_count[ch*16 +: 16];
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_bus();
      bus.valid = '0;
      bus.ready = '0;
      bus.data  = '0;
      clear     = 1'b0;
   endtask

   task automatic do_reset();
      idle_bus();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({err_valid_drop, err_data_change, err_stall_timeout} !== 9'h0) begin
         bad++;
         $display("FAIL reset_flags got=%h want=0",
                  {err_valid_drop, err_data_change, err_stall_timeout});
      end
      total++;
      if ({xfer_count, any_error, first_err_valid, first_err_ch} !== 52'h0) begin
         bad++;
         $display("FAIL reset_outs cnt=%h any=%b fev=%b fch=%0d want 0",
                  xfer_count, any_error, first_err_valid, first_err_ch);
      end
   endtask

   task automatic test_clean();
      logic [1:0] v1 [5] = '{1, 1, 1, 1, 0};
      logic [1:0] r1 [5] = '{0, 1, 0, 1, 0};
      logic [3:0] d1 [5] = '{4'h7, 4'h7, 4'h2, 4'h2, 4'h0};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         bus.valid = {1'b0, v1[k][0], 1'b1};
         bus.ready = {1'b0, r1[k][0], 1'b1};
         bus.data  = {4'h0, d1[k], 4'h9};
         step();
      end
      idle_bus();
      total++;
      if (cnt(0) !== 16'd5) begin
         bad++;
         $display("FAIL clean_cnt0 got=%0d want=5", cnt(0));
      end
      total++;
      if (cnt(1) !== 16'd2) begin
         bad++;
         $display("FAIL clean_cnt1 got=%0d want=2", cnt(1));
      end
      total++;
      if ({err_valid_drop, err_data_change, err_stall_timeout,
           any_error, first_err_valid} !== 11'h0) begin
         bad++;
         $display("FAIL clean_err vd=%b dc=%b to=%b any=%b fev=%b want 0",
                  err_valid_drop, err_data_change, err_stall_timeout,
                  any_error, first_err_valid);
      end
   endtask

   task automatic test_valid_drop();
      do_reset();
      bus.valid = 3'b010;
      bus.data  = 12'h0A0;
      step();
      step();
      total++;
      if (err_valid_drop !== 3'b000) begin
         bad++;
         $display("FAIL drop_early got=%b want=000", err_valid_drop);
      end
      bus.valid = 3'b000;
      step();
      total++;
      if (err_valid_drop !== 3'b010 || any_error !== 1'b1) begin
         bad++;
         $display("FAIL drop_flag vd=%b any=%b want 010/1",
                  err_valid_drop, any_error);
      end
      total++;
      if (first_err_valid !== 1'b1 || first_err_ch !== 2'd1) begin
         bad++;
         $display("FAIL drop_first fev=%b ch=%0d want 1/1",
                  first_err_valid, first_err_ch);
      end
      total++;
      if (cnt(1) !== 16'd0) begin
         bad++;
         $display("FAIL drop_cnt got=%0d want=0", cnt(1));
      end
   endtask

   task automatic test_data_change();
      do_reset();
      bus.valid = 3'b100;
      bus.data  = 12'h300;
      step();
      bus.data  = 12'h500;
      step();
      total++;
      if (err_data_change !== 3'b100) begin
         bad++;
         $display("FAIL dchg_flag got=%b want=100", err_data_change);
      end
      bus.ready = 3'b100;
      step();
      idle_bus();
      total++;
      if (cnt(2) !== 16'd1 || err_data_change !== 3'b100) begin
         bad++;
         $display("FAIL dchg_accept cnt=%0d dc=%b want 1/100",
                  cnt(2), err_data_change);
      end
      total++;
      if (err_valid_drop !== 3'b000 || err_stall_timeout !== 3'b000) begin
         bad++;
         $display("FAIL dchg_other vd=%b to=%b want 000",
                  err_valid_drop, err_stall_timeout);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      bus.valid = 3'b001;
      bus.data  = 12'h00C;
      for (int k = 1; k <= 3; k++) step();
      total++;
      if (err_stall_timeout !== 3'b000) begin
         bad++;
         $display("FAIL tmo_early got=%b want=000", err_stall_timeout);
      end
      step();
      total++;
      if (err_stall_timeout !== 3'b001 || first_err_ch !== 2'd0
          || first_err_valid !== 1'b1) begin
         bad++;
         $display("FAIL tmo_fire to=%b fev=%b ch=%0d want 001/1/0",
                  err_stall_timeout, first_err_valid, first_err_ch);
      end
      // Clear mid-stall: a saturated stall must not fire again.
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();
      total++;
      if (err_stall_timeout !== 3'b000 || any_error !== 1'b0) begin
         bad++;
         $display("FAIL tmo_once to=%b any=%b want 000/0",
                  err_stall_timeout, any_error);
      end
   endtask

   task automatic test_simul_clear();
      do_reset();
      bus.valid = 3'b101;
      bus.data  = 12'h101;
      step();
      bus.valid = 3'b110;
      bus.data  = 12'h200;
      step();
      total++;
      if (err_valid_drop !== 3'b001 || err_data_change !== 3'b100
          || first_err_ch !== 2'd0 || first_err_valid !== 1'b1) begin
         bad++;
         $display("FAIL simul vd=%b dc=%b fev=%b ch=%0d want 001/100/1/0",
                  err_valid_drop, err_data_change, first_err_valid,
                  first_err_ch);
      end
      clear     = 1'b1;
      bus.valid = 3'b100;
      bus.ready = 3'b100;
      bus.data  = 12'h100;
      step();
      idle_bus();
      total++;
      if (err_valid_drop !== 3'b010 || err_data_change !== 3'b000
          || err_stall_timeout !== 3'b000) begin
         bad++;
         $display("FAIL clr_flags vd=%b dc=%b to=%b want 010/000/000",
                  err_valid_drop, err_data_change, err_stall_timeout);
      end
      total++;
      if (first_err_valid !== 1'b1 || first_err_ch !== 2'd1
          || any_error !== 1'b1 || cnt(2) !== 16'd1) begin
         bad++;
         $display("FAIL clr_first fev=%b ch=%0d any=%b c2=%0d want 1/1/1/1",
                  first_err_valid, first_err_ch, any_error, cnt(2));
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      bus.valid = 3'b011;
      bus.ready = 3'b001;
      bus.data  = 12'h060;
      step();
      bus.valid = 3'b010;
      bus.ready = 3'b000;
      step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      total++;
      if ({xfer_count, any_error, first_err_valid} !== 50'h0
          || {err_valid_drop, err_data_change, err_stall_timeout} !== 9'h0) begin
         bad++;
         $display("FAIL rst_mid cnt=%h any=%b fev=%b want 0",
                  xfer_count, any_error, first_err_valid);
      end
      bus.valid = 3'b000;
      step();
      step();
      total++;
      if (err_valid_drop !== 3'b000 || any_error !== 1'b0) begin
         bad++;
         $display("FAIL rst_nodrop vd=%b any=%b want 000/0",
                  err_valid_drop, any_error);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      bus.valid = 3'b001;
      bus.ready = 3'b001;
      for (int k = 0; k < 65534; k++) step();
      total++;
      if (cnt(0) !== 16'hFFFE) begin
         bad++;
         $display("FAIL sat_pre got=%h want=fffe", cnt(0));
      end
      for (int k = 0; k < 4; k++) step();
      idle_bus();
      total++;
      if (cnt(0) !== 16'hFFFF) begin
         bad++;
         $display("FAIL sat_hold got=%h want=ffff", cnt(0));
      end
   endtask

   initial begin
      RESET = 1'b1;
      idle_bus();
      test_reset();
      test_clean();
      test_valid_drop();
      test_data_change();
      test_timeout();
      test_simul_clear();
      test_reset_mid_stall();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
